// File: rtl/fsm_z_pkg.sv
// Shared types and constants for the Z-output collector.
// Holds the collector state enum, the default word width and the bit-count width helper.
// No ports; imported by fsm_z_holdreg and fsm_z_collector.
package fsm_z_pkg;

    // Collector FSM. Word completion is decided combinationally,
    // so there is no registered EMIT state.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } coll_state_e;

    localparam int DEFAULT_W = 8;

    // Width needed to hold a count in the range 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fsm_z_holdreg.sv
// One-entry valid/ready holding register for completed words, with sticky overrun.
// Latency: a word loaded on edge N is visible (valid) from cycle N+1.
// Backpressure: a load while full and not draining is dropped and sets overrun.
// Ports:
//   clk, reset                  clock / async active-high reset
//   load_vld, load_dat, load_bits  completed word from the collector
//   word_*                      registered output word and handshake
//   overrun_clr, overrun        sticky drop flag (set wins over clear)
// Optional macro FSM_Z_COLLECTOR_PARITY_EN adds word_parity, registered with the data.
module fsm_z_holdreg #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_vld,
    input  logic [W-1:0]     load_dat,
    input  logic [CNT_W-1:0] load_bits,
    input  logic             word_ready,
    input  logic             overrun_clr,
    output logic [W-1:0]     word_data,
    output logic [CNT_W-1:0] word_bits,
    output logic             word_valid,
    output logic             overrun
`ifdef FSM_Z_COLLECTOR_PARITY_EN
   ,output logic             word_parity
`endif
);

    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             can_load;

    // The slot is free either when empty or when it drains on this same edge.
    assign accept   = valid_q & word_ready;
    assign can_load = ~valid_q | accept;

    always_comb begin
        data_d  = data_q;
        bits_d  = bits_q;
        valid_d = valid_q;
        if (load_vld && can_load) begin
            data_d  = load_dat;
            bits_d  = load_bits;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        // A new drop takes priority over a clear on the same cycle.
        ovr_d = (load_vld & ~can_load) | (ovr_q & ~overrun_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            bits_q  <= bits_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_data  = data_q;
    assign word_bits  = bits_q;
    assign word_valid = valid_q;
    assign overrun    = ovr_q;

`ifdef FSM_Z_COLLECTOR_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (load_vld && can_load) begin
            parity_q <= ^load_dat;
        end
    end

    assign word_parity = parity_q;
`endif

endmodule

// File: rtl/fsm_z_collector.sv
// Samples the detector FSM's Z output and packs it LSB-first into W-bit words.
// Latency: word_valid rises the cycle after the completing sample or flush.
// Backpressure: one holding slot; a completion while it is full and not draining drops the word and sets overrun.
// Ports:
//   clk, reset                 clock / async active-high reset
//   sample_en, z_in, flush     sample stream and partial-word flush
//   word_data/bits/valid/ready output word handshake
//   overrun, overrun_clr       sticky dropped-word flag
//   collecting                 shift register holds at least one bit
// Optional macro FSM_Z_COLLECTOR_PARITY_EN adds word_parity (XOR of word_data).
module fsm_z_collector
    import fsm_z_pkg::*;
#(
    parameter  int W     = DEFAULT_W,
    localparam int CNT_W = cnt_w(W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             z_in,
    input  logic             flush,
    input  logic             overrun_clr,
    output logic [W-1:0]     word_data,
    output logic [CNT_W-1:0] word_bits,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic             collecting
`ifdef FSM_Z_COLLECTOR_PARITY_EN
   ,output logic             word_parity
`endif
);

    coll_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     shift_q, shift_d;

    logic [W-1:0]     shift_ins;
    logic [CNT_W-1:0] cnt_ins;
    logic             complete;
    logic             load_vld;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        // Word including this cycle's sample, so a completing edge captures it.
        shift_ins = shift_q;
        for (int i = 0; i < W; i++) begin
            if (sample_en && cnt_q == CNT_W'(i)) begin
                shift_ins[i] = z_in;
            end
        end
        cnt_ins = cnt_q + CNT_W'(sample_en);

        // Full word on the W-th sample, or flush with anything to send.
        complete = (sample_en && cnt_q == CNT_W'(W - 1))
                 || (flush && (cnt_q != '0 || sample_en));

        state_d = state_q;
        cnt_d   = cnt_ins;
        shift_d = shift_ins;
        if (complete) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            case (state_q)
                IDLE:    if (sample_en) state_d = COLLECT;
                COLLECT: state_d = COLLECT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        load_vld   = complete;
        collecting = (cnt_q != '0);
    end

    fsm_z_holdreg #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_holdreg (
        .clk         (clk),
        .reset       (reset),
        .load_vld    (load_vld),
        .load_dat    (shift_ins),
        .load_bits   (cnt_ins),
        .word_ready  (word_ready),
        .overrun_clr (overrun_clr),
        .word_data   (word_data),
        .word_bits   (word_bits),
        .word_valid  (word_valid),
        .overrun     (overrun)
`ifdef FSM_Z_COLLECTOR_PARITY_EN
       ,.word_parity (word_parity)
`endif
    );

endmodule

// File: tb/tb_fsm_z_collector.sv
// Self-checking bench for fsm_z_collector (W=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_fsm_z_collector;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_en, z_in, flush, overrun_clr, word_ready;
    logic [W-1:0]     word_data;
    logic [CNT_W-1:0] word_bits;
    logic             word_valid, overrun, collecting;
`ifdef FSM_Z_COLLECTOR_PARITY_EN
    logic             word_parity;
`endif

    always #5 clk = ~clk;

    fsm_z_collector #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_en   (sample_en),
        .z_in        (z_in),
        .flush       (flush),
        .overrun_clr (overrun_clr),
        .word_data   (word_data),
        .word_bits   (word_bits),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .collecting  (collecting)
`ifdef FSM_Z_COLLECTOR_PARITY_EN
       ,.word_parity (word_parity)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int           m_cnt;
    logic [W-1:0] m_acc;
    logic         m_hv;
    logic [W-1:0] m_hd;
    int           m_hb;
    logic         m_ovr;

    task automatic model_reset();
        m_cnt = 0; m_acc = '0; m_hv = 1'b0; m_hd = '0; m_hb = 0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input logic se, input logic z, input logic fl,
                              input logic rdy, input logic clr);
        bit done, xfer, ovr_new;
        if (se) begin
            m_acc[m_cnt] = z;
            m_cnt++;
        end
        done    = (m_cnt == W) || (fl && m_cnt > 0);
        xfer    = m_hv && rdy;
        ovr_new = 1'b0;
        if (done) begin
            if (!m_hv || xfer) begin
                m_hv = 1'b1; m_hd = m_acc; m_hb = m_cnt;
            end else begin
                ovr_new = 1'b1;
            end
            m_acc = '0;
            m_cnt = 0;
        end else if (xfer) begin
            m_hv = 1'b0;
        end
        m_ovr = ovr_new || (m_ovr && !clr);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},   32'(word_valid), 32'(m_hv));
        chk({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
        chk({tag, ".collect"}, 32'(collecting), 32'(m_cnt != 0));
        if (m_hv) begin
            chk({tag, ".data"}, 32'(word_data), 32'(m_hd));
            chk({tag, ".bits"}, 32'(word_bits), 32'(m_hb));
`ifdef FSM_Z_COLLECTOR_PARITY_EN
            chk({tag, ".parity"}, 32'(word_parity), 32'(^m_hd));
`endif
        end
    endtask

    // Drive inputs 1 time unit after a rising edge, advance one clock, sample at +1.
    task automatic step(input logic se, input logic z, input logic fl,
                        input logic rdy, input logic clr);
        sample_en = se; z_in = z; flush = fl; word_ready = rdy; overrun_clr = clr;
        @(posedge clk);
        model_step(se, z, fl, rdy, clr);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".data"},    32'(word_data),  32'd0);
        chk({tag, ".bits"},    32'(word_bits),  32'd0);
        chk({tag, ".valid"},   32'(word_valid), 32'd0);
        chk({tag, ".overrun"}, 32'(overrun),    32'd0);
        chk({tag, ".collect"}, 32'(collecting), 32'd0);
`ifdef FSM_Z_COLLECTOR_PARITY_EN
        chk({tag, ".parity"},  32'(word_parity), 32'd0);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             se, z, fl, rdy, clr;
        logic [W-1:0]     e_data;
        logic [CNT_W-1:0] e_bits;
        logic             e_vld, e_ovr, e_coll;
    } vec_t;

    vec_t tbl [17];

    initial begin
        reset = 1'b1; sample_en = 0; z_in = 0; flush = 0; overrun_clr = 0; word_ready = 0;
        model_reset();

        //        se z fl rdy clr  data    bits  vld ovr coll
        tbl = '{
            '{1, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 1, 0, 1, 0, 8'h8D, 4'd8, 1, 0, 0},
            '{0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 0},
            '{1, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 1},
            '{0, 0, 1, 1, 0, 8'h03, 4'd3, 1, 0, 0},
            '{0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 0},
            '{0, 0, 1, 1, 0, 8'h00, 4'd0, 0, 0, 0},
            '{1, 1, 1, 1, 0, 8'h01, 4'd1, 1, 0, 0},
            '{0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 0}
        };

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Table-driven vectors
        foreach (tbl[i]) begin
            step(tbl[i].se, tbl[i].z, tbl[i].fl, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d.valid", i),   32'(word_valid), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d.overrun", i), 32'(overrun),    32'(tbl[i].e_ovr));
            chk($sformatf("vec%0d.collect", i), 32'(collecting), 32'(tbl[i].e_coll));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d.data", i), 32'(word_data), 32'(tbl[i].e_data));
                chk($sformatf("vec%0d.bits", i), 32'(word_bits), 32'(tbl[i].e_bits));
`ifdef FSM_Z_COLLECTOR_PARITY_EN
                chk($sformatf("vec%0d.parity", i), 32'(word_parity), 32'(^tbl[i].e_data));
`endif
            end
        end

        // Overrun: ready held low over 16 alternating samples
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'(i % 2 == 0), 1'b0, 1'b0, 1'b0);
            compare_all($sformatf("ovr_s%0d", i));
        end
        chk("ovr.flag",  32'(overrun),    32'd1);
        chk("ovr.data",  32'(word_data),  32'h55);
        chk("ovr.valid", 32'(word_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.clear", 32'(overrun), 32'd0);
        compare_all("ovr_clr");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_all("ovr_drain");

        // Ready rises on the same edge the next word (0xF0) completes
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'(i >= 4), 1'b0, 1'(i == 7), 1'b0);
        chk("b2b.valid",   32'(word_valid), 32'd1);
        chk("b2b.data",    32'(word_data),  32'hF0);
        chk("b2b.overrun", 32'(overrun),    32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_all("b2b_drain");

        // Small word for parity: 0x07
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("w07.data", 32'(word_data), 32'h07);
        chk("w07.bits", 32'(word_bits), 32'd3);
`ifdef FSM_Z_COLLECTOR_PARITY_EN
        chk("w07.parity", 32'(word_parity), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped samples, then reset mid-word
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("gap.collect", 32'(collecting), 32'd1);
        reset = 1'b1;
        #2;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ff.data",  32'(word_data),  32'hFF);
        chk("ff.bits",  32'(word_bits),  32'd8);
        chk("ff.valid", 32'(word_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the reference model
        begin
            logic busy;
            busy = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 63) == 0) busy = ~busy;
                step(1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 7) == 0),
                     busy ? 1'($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 15) == 0));
                compare_all($sformatf("rnd%0d", c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_z_collector.md
Name: fsm_z_collector

Overview:
- Downstream stage of the serial Mealy detector FSM.
- Samples the FSM's 1-bit output Z on qualified cycles and packs the bits LSB-first into W-bit words.
- Presents each word on a valid/ready interface toward the bus/CSR side.
- Has one holding register, so the next word keeps collecting while the previous one waits; supports partial-word flush and a sticky overrun flag.

Parameters:
- W, 8, word width in bits (W ≥ 2)
- CNT_W, $clog2(W+1), width of bit-count fields (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sample_en  in  1  Z from the FSM is valid this cycle
- z_in  in  1  Z output of the detector FSM
- flush  in  1  push the current partial word
- overrun_clr  in  1  clears the sticky overrun flag
- word_data  out  W  packed word; bit0 is the oldest sample
- word_bits  out  CNT_W  number of valid bits in word_data (1..W)
- word_valid  out  1  holding register full
- word_ready  in  1  consumer accepts the word
- overrun  out  1  sticky: a completed word was dropped
- collecting  out  1  shift register holds ≥1 bit

Behaviour:
- Reset: all registers clear asynchronously. word_data=0, word_bits=0, word_valid=0, overrun=0, collecting=0, bit counter=0, FSM in IDLE.
- Collect FSM states:
  - IDLE: counter 0. sample_en moves to COLLECT with counter=1.
  - COLLECT: each sample_en writes z_in to shift bit [counter] and increments counter.
  - EMIT: not a registered state. Completion is decided combinationally on the completing edge.
- Completion: the cycle where sample_en makes counter reach W, or flush=1 with (counter>0 or sample_en).
  - On that edge the complete word (including the same-cycle sample) loads the holding register.
  - word_bits = resulting count; unused upper bits = 0.
  - Shift register and counter clear; FSM returns to IDLE.
  - Latency: word_valid is high the cycle after the completing sample.
- flush with counter=0 and sample_en=0: ignored, no word produced.
- flush and the W-th sample in the same cycle: a single full word (word_bits=W).
- Output handshake: transfer occurs when word_valid && word_ready. word_valid drops next cycle unless a new word loads on that edge. word_data/word_bits stay stable while valid && !ready.
- Completion while the holding register is full:
  - If the same cycle is a transfer, the new word loads and word_valid stays 1.
  - Otherwise the new word is discarded, the holding register is unchanged, overrun sets to 1, and collection restarts from IDLE.
- overrun stays set until overrun_clr. If overrun_clr and a new overrun coincide, overrun stays 1 (set wins).
- word_ready with word_valid=0: no effect.
- collecting = (counter != 0).
- Reset mid-word: the partial word and any held word are lost; no output is produced.

Optional Feature:
- Macro: FSM_Z_COLLECTOR_PARITY_EN
- Defined: adds output port word_parity (1 bit), the XOR of word_data[W-1:0]. It is registered alongside the holding register with the same timing, and is 0 at reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fsm_z_pkg:
  - collector state enum (IDLE, COLLECT)
  - default word width constant
  - the CNT_W computation function
- Natural sub-module: fsm_z_holdreg, a one-entry valid/ready holding register with load/accept/overrun logic.
- Shift and count logic stays in the top module.

Test Plan:
- W=8, ready=1, samples 1,0,1,1,0,0,0,1 on consecutive cycles -> next cycle word_valid=1, word_data=0x8D, word_bits=8; word_valid=0 the following cycle.
- Samples 1,1,0, then flush alone -> word_data=0x03, word_bits=3. A second flush with an empty collector -> no word_valid pulse.
- ready=0, 16 samples of alternating 1,0 -> first word 0x55 held, overrun=1 after bit 16, word_data still 0x55. overrun_clr -> overrun=0.
- Held word with ready rising on the same edge the next word completes (0xF0) -> no overrun, word_valid continuous, word_data=0xF0.
- sample_en gaps (one bit every 3 cycles) and a reset asserted after 5 bits -> all outputs 0. A fresh 8 bits of 1 -> word_data=0xFF.
- With PARITY_EN defined: word 0x8D -> word_parity=0; word 0x07 -> word_parity=1.
